// File: rtl/spi_master_ram_if.sv
// SPI command initiator for the SPI slave / single-port RAM subsystem.
// Each accepted command becomes one SS_n-framed MOSI transfer; read-data frames also collect an 8-bit MISO reply.
module spi_master_ram_if #(
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       seq_err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, RECV, DONE, GAP} state_t;

    state_t      state, state_nxt;
    logic [9:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic [3:0]  cnt;
    logic        is_read;
    logic        err_pend;
    logic        wa_pend;
    logic        ra_pend;
    logic        accept;

    assign accept = cmd_valid && cmd_ready;

    // The shared counter restarts on every state change, so each phase counts from zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd9) state_nxt = is_read ? WAIT : DONE;
            WAIT:    if (cnt == 4'(RD_LATENCY - 1)) state_nxt = RECV;
            RECV:    if (cnt == 4'd7) state_nxt = DONE;
            DONE:    state_nxt = GAP;
            GAP:     if (cnt == 4'(IDLE_GAP - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            tx_shift <= 10'd0;
            rx_shift <= 8'd0;
            rd_data  <= 8'd0;
            is_read  <= 1'b0;
            err_pend <= 1'b0;
            wa_pend  <= 1'b0;
            ra_pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
            if (accept) begin
                tx_shift <= {cmd_op, cmd_data};
                is_read  <= (cmd_op == 2'b11);
                err_pend <= ((cmd_op == 2'b01) && !wa_pend) || ((cmd_op == 2'b11) && !ra_pend);
                case (cmd_op)
                    2'b00:   wa_pend <= 1'b1;
                    2'b01:   wa_pend <= 1'b0;
                    2'b10:   ra_pend <= 1'b1;
                    default: ra_pend <= 1'b0;
                endcase
            end else if (state == SHIFT) begin
                tx_shift <= {tx_shift[8:0], 1'b0};
            end
            if (state == RECV) begin
                rx_shift <= {rx_shift[6:0], MISO};
            end
            if ((state == RECV) && (cnt == 4'd7)) begin
                rd_data <= {rx_shift[6:0], MISO};
            end
        end
    end

    // START repeats op[1] ahead of the shifted frame, so MOSI reads the unshifted MSB there too.
    always_comb begin
        SS_n      = !((state == START) || (state == SHIFT) || (state == WAIT) || (state == RECV));
        MOSI      = ((state == START) || (state == SHIFT)) ? tx_shift[9] : 1'b0;
        rd_valid  = (state == DONE) && is_read;
        seq_err   = (state == START) && err_pend;
        busy      = (state != IDLE);
        cmd_ready = rst_n && (state == IDLE);
    end

endmodule

// File: tb/tb_spi_master_ram_if.sv
// Bench for spi_master_ram_if: a frame-timeline model predicts every output each cycle,
// with directed literal checks and randomized command sequences.
module tb_spi_master_ram_if;

    localparam int RD_LATENCY = 2;
    localparam int IDLE_GAP   = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       MISO = 1'b0;
    logic       cmd_ready;
    logic       SS_n;
    logic       MOSI;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       seq_err;
    logic       busy;

    always #5 clk = ~clk;

    spi_master_ram_if #(.RD_LATENCY(RD_LATENCY), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rd_valid(rd_valid), .rd_data(rd_data), .seq_err(seq_err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: one frame described by its accept cycle; outputs are a function of the offset from it.
    int          cyc = 0;
    int          m_t = 0;
    bit          m_active = 0;
    bit          m_read = 0;
    bit          m_err = 0;
    bit          m_wa = 0;
    bit          m_ra = 0;
    logic [10:0] m_bits = '0;
    logic [7:0]  m_reply = '0;
    logic [7:0]  m_rdata = '0;
    logic [7:0]  next_reply = '0;
    int          m_acc = 0;

    function automatic int done_off();
        return m_read ? 20 + RD_LATENCY : 12;
    endfunction

    function automatic bit model_ready();
        return !m_active || ((cyc - m_t) > done_off() + IDLE_GAP);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_wa     = 0;
            m_ra     = 0;
            m_rdata  = 8'h00;
        end else begin
            if (cmd_valid && model_ready()) begin
                m_t      = cyc;
                m_active = 1;
                m_read   = (cmd_op == 2'b11);
                m_bits   = {cmd_op[1], cmd_op, cmd_data};
                m_reply  = next_reply;
                m_err    = ((cmd_op == 2'b01) && !m_wa) || ((cmd_op == 2'b11) && !m_ra);
                if (cmd_op == 2'b00) m_wa = 1;
                if (cmd_op == 2'b01) m_wa = 0;
                if (cmd_op == 2'b10) m_ra = 1;
                if (cmd_op == 2'b11) m_ra = 0;
                m_acc++;
            end
            cyc++;
            if (m_active && m_read && (cyc - m_t) == done_off()) m_rdata = m_reply;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Compare process: every output, every cycle.
    always @(negedge clk) begin
        int   d;
        logic e_ss, e_mosi, e_rv, e_se, e_busy, e_ready;
        d       = cyc - m_t;
        e_busy  = m_active && (d >= 1) && (d <= done_off() + IDLE_GAP);
        e_ss    = !(m_active && (d >= 1) && (d < done_off()));
        e_mosi  = (m_active && (d >= 1) && (d <= 11)) ? m_bits[11 - d] : 1'b0;
        e_rv    = m_active && m_read && (d == done_off());
        e_se    = m_active && m_err && (d == 1);
        e_ready = rst_n && !e_busy;
        checkOutput("SS_n", 32'(SS_n), 32'(e_ss));
        checkOutput("MOSI", 32'(MOSI), 32'(e_mosi));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        checkOutput("rd_valid", 32'(rd_valid), 32'(e_rv));
        checkOutput("seq_err", 32'(seq_err), 32'(e_se));
        checkOutput("rd_data", 32'(rd_data), 32'(m_rdata));
    end

    // Slave reply: the model's byte during the receive window, noise elsewhere.
    initial begin
        forever begin
            int d;
            @(posedge clk);
            #1;
            d = cyc - m_t;
            if (m_active && m_read && (d >= 12 + RD_LATENCY) && (d < 20 + RD_LATENCY))
                MISO = m_reply[7 - (d - 12 - RD_LATENCY)];
            else
                MISO = 1'($urandom_range(0, 1));
        end
    end

    int ss_run = 0;
    int last_run = 0;
    int rv_count = 0;

    always @(negedge clk) begin
        if (!SS_n) ss_run++;
        else if (ss_run != 0) begin
            last_run = ss_run;
            ss_run   = 0;
        end
        if (rd_valid) rv_count++;
    end

    // Called just after a rising edge; returns #1 into the cycle after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data,
                                 input logic [7:0] reply, input bit keep_valid);
        int start_acc;
        int budget;
        start_acc  = m_acc;
        next_reply = reply;
        cmd_op     = op;
        cmd_data   = data;
        cmd_valid  = 1'b1;
        budget     = 0;
        while ((m_acc == start_acc) && (budget < 200)) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (m_acc == start_acc) checkOutput("accept_timeout", 32'd0, 32'd1);
        if (!keep_valid) cmd_valid = 1'b0;
        cmd_op   = 2'($urandom);
        cmd_data = 8'($urandom);
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        while (!model_ready() && (budget < 200)) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!model_ready()) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    // Called just after a rising edge.
    task automatic doReset();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_SS_n", 32'(SS_n), 32'd1);
        checkOutput("rst_MOSI", 32'(MOSI), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_seq_err", 32'(seq_err), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkMosiLiteral(input string name, input logic [10:0] lit);
        logic [10:0] v;
        v = lit;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            checkOutput(name, 32'(MOSI), 32'(v[11 - k]));
            checkOutput("lit_ss_low", 32'(SS_n), 32'd0);
            checkOutput("lit_no_seq_err", 32'(seq_err), 32'd0);
        end
    endtask

    initial begin
        int rv_before;
        @(posedge clk);
        doReset();

        applyStimulus(2'b00, 8'h5A, 8'h00, 1'b0);
        checkMosiLiteral("lit_mosi_5A", 11'b000_0101_1010);
        @(negedge clk);
        checkOutput("lit_ss_rise_T12", 32'(SS_n), 32'd1);
        checkOutput("lit_ready_T12", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("lit_ready_T14", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(2'b01, 8'hC3, 8'h00, 1'b0);
        checkMosiLiteral("lit_mosi_C3", 11'b001_1100_0011);
        waitIdle();

        applyStimulus(2'b10, 8'h11, 8'h00, 1'b0);
        waitIdle();
        rv_before = rv_count;
        applyStimulus(2'b11, 8'hFF, 8'hA5, 1'b0);
        @(negedge clk);
        checkOutput("lit_read_no_seq_err", 32'(seq_err), 32'd0);
        waitIdle();
        checkOutput("lit_read_frame_len", 32'(last_run), 32'd21);
        checkOutput("lit_read_rd_data", 32'(rd_data), 32'hA5);
        checkOutput("lit_read_rv_pulses", 32'(rv_count - rv_before), 32'd1);

        @(posedge clk);
        doReset();
        applyStimulus(2'b11, 8'h00, 8'h3C, 1'b0);
        @(negedge clk);
        checkOutput("lit_orphan_seq_err", 32'(seq_err), 32'd1);
        waitIdle();
        checkOutput("lit_orphan_rd_data", 32'(rd_data), 32'h3C);

        for (int i = 0; i < 40; i++) begin
            bit keep;
            keep = (i != 39) && ($urandom_range(0, 1) == 1);
            applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), keep);
            if (!keep) begin
                waitIdle();
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        waitIdle();

        rv_before = rv_count;
        applyStimulus(2'b00, 8'($urandom), 8'h00, 1'b0);
        repeat (6) @(posedge clk);
        doReset();
        checkOutput("lit_abort_no_rd_valid", 32'(rv_count - rv_before), 32'd0);
        applyStimulus(2'b10, 8'h77, 8'h00, 1'b0);
        checkMosiLiteral("lit_mosi_after_abort", 11'b110_0111_0111);
        waitIdle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
